// File: rtl/str_pack.sv
// str_pack: stream width up-converter, RATIO input beats of DW bits -> one
// DW*RATIO output word, first accepted beat in lane 0. The output side is a
// forward register slice: odata/okeep/olast/ovalid are registered and held
// while the consumer stalls.
//
// Optional feature macro: STR_PACK_LAST_EN
//   defined   : ilast/okeep/olast ports exist; ilast flushes a partial word
//               with unused upper lanes zeroed.
//   undefined : those ports are absent; a word is emitted every RATIO beats.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   idata/ivalid  input beat and its valid
//   iready        input ready (= ~ovalid | oready)
//   ilast         packet end marker on the input beat (STR_PACK_LAST_EN)
//   odata         packed word, lane k = odata[k*DW +: DW]
//   okeep/olast   lane-valid mask and packet end (STR_PACK_LAST_EN)
//   ovalid/oready output handshake
module str_pack #(
  parameter int unsigned DW    = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         idata,
  input  logic                  ivalid,
  output logic                  iready,
`ifdef STR_PACK_LAST_EN
  input  logic                  ilast,
  output logic [RATIO-1:0]      okeep,
  output logic                  olast,
`endif
  output logic [DW*RATIO-1:0]   odata,
  output logic                  ovalid,
  input  logic                  oready
);

  localparam int unsigned WCW = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam int unsigned OW  = DW * RATIO;
  localparam int unsigned AW  = DW * (RATIO - 1);
  localparam logic [WCW-1:0] WC_MAX = WCW'(RATIO - 1);

  if (RATIO < 2) begin : g_ratio_check
    $error("str_pack: RATIO must be >= 2");
  end

  logic [WCW-1:0] wc;
  logic [AW-1:0]  acc;
  logic [OW-1:0]  acc_ext;
  logic [OW-1:0]  word_c;
  logic           ish;
  logic           done;
  logic           ilast_i;

  // Input is ready whenever the output register is empty or draining.
  assign iready = ~ovalid | oready;
  assign ish    = ivalid & iready;

`ifdef STR_PACK_LAST_EN
  assign ilast_i = ilast;
`else
  assign ilast_i = 1'b0;
`endif

  assign done    = ish & ((wc == WC_MAX) | ilast_i);
  assign acc_ext = {{DW{1'b0}}, acc};

  // Completed word: current beat in lane wc, earlier lanes from acc, rest zero.
  always_comb begin
    word_c = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (WCW'(k) == wc) begin
        word_c[k*DW +: DW] = idata;
      end else if (WCW'(k) < wc) begin
        word_c[k*DW +: DW] = acc_ext[k*DW +: DW];
      end
    end
  end

`ifdef STR_PACK_LAST_EN
  logic [RATIO-2:0] akeep;
  logic [RATIO-1:0] keep_c;

  // Lanes already accumulated plus the lane taken by the completing beat.
  assign keep_c = {1'b0, akeep} | (RATIO'(1) << wc);

  always_ff @(posedge clk) begin
    if (rst) begin
      akeep <= '0;
      okeep <= '0;
      olast <= 1'b0;
    end else if (done) begin
      akeep <= '0;
      okeep <= keep_c;
      olast <= ilast_i;
    end else if (ish) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        if (wc == WCW'(k)) akeep[k] <= 1'b1;
      end
    end
  end
`endif

  // Accumulator, lane counter and output register slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      wc     <= '0;
      acc    <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
    end else begin
      if (done) begin
        odata <= word_c;
        wc    <= '0;
        acc   <= '0;
      end else if (ish) begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (wc == WCW'(k)) acc[k*DW +: DW] <= idata;
        end
        wc <= wc + WCW'(1);
      end
      // A new word may load in the same cycle the old one is taken.
      if (done) begin
        ovalid <= 1'b1;
      end else if (oready) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_str_pack.sv
module tb_str_pack;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OW    = DW * RATIO;
`ifdef STR_PACK_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [DW-1:0] idata;
  logic          ivalid;
  logic          iready;
  logic [OW-1:0] odata;
  logic          ovalid;
  logic          oready;
`ifdef STR_PACK_LAST_EN
  logic             ilast;
  logic [RATIO-1:0] okeep;
  logic             olast;
`endif

  str_pack #(.DW(DW), .RATIO(RATIO)) dut (
    .clk    (clk),
    .rst    (rst),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
`ifdef STR_PACK_LAST_EN
    .ilast  (ilast),
    .okeep  (okeep),
    .olast  (olast),
`endif
    .odata  (odata),
    .ovalid (ovalid),
    .oready (oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0]    w;
    logic [RATIO-1:0] k;
    logic             l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Values observed just before the active edge of the last step.
  logic             s_irdy, s_ov, s_ish, s_osh, s_ol;
  logic [OW-1:0]    s_od;
  logic [RATIO-1:0] s_ok;

  // Reference packer state.
  logic [OW-1:0]    m_word;
  logic [RATIO-1:0] m_keep;
  int               m_wc;

  // Drive one cycle at the falling edge, record handshakes, update the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    exp_t e;
    logic le;
    le     = l & LAST_EN;
    ivalid = v;
    idata  = d;
    oready = r;
`ifdef STR_PACK_LAST_EN
    ilast  = l;
`endif
    #1;
    s_irdy = iready;
    s_ov   = ovalid;
    s_ish  = v & iready & ~rst;
    s_osh  = ovalid & r & ~rst;
    s_od   = odata;
`ifdef STR_PACK_LAST_EN
    s_ok   = okeep;
    s_ol   = olast;
`else
    s_ok   = '1;
    s_ol   = 1'b0;
`endif
    if (rst) begin
      m_word = '0; m_keep = '0; m_wc = 0;
      q.delete();
    end else if (s_ish) begin
      m_word[m_wc*DW +: DW] = d;
      m_keep[m_wc] = 1'b1;
      if (m_wc == RATIO - 1 || le) begin
        e.w = m_word; e.k = m_keep; e.l = le;
        q.push_back(e);
        m_word = '0; m_keep = '0; m_wc = 0;
      end else begin
        m_wc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (ovalid !== 1'b0 || odata !== '0 || iready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ovalid=%b odata=%h iready=%b, required 0 0 1", ovalid, odata, iready);
    end
`ifdef STR_PACK_LAST_EN
    checks++;
    if (okeep !== '0 || olast !== 1'b0) begin
      errors++;
      $display("FAIL reset_keep: okeep=%b olast=%b, required 0 0", okeep, olast);
    end
`endif
  endtask

  task automatic test_full_rate();
    exp_t e;
    logic [OW-1:0] want;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) step(1'b1, DW'(i), 1'b0, 1'b1);
      else        step(1'b0, '0, 1'b0, 1'b1);
      if (s_osh) begin
        checks++;
        e = q.pop_front();
        if (s_od !== e.w || s_ok !== e.k || s_ol !== e.l) begin
          errors++;
          $display("FAIL full_rate_sb: got %h/%b/%b, required %h/%b/%b", s_od, s_ok, s_ol, e.w, e.k, e.l);
        end
      end
      if (i <= 8) begin
        checks++;
        if (s_irdy !== 1'b1) begin
          errors++;
          $display("FAIL full_rate_iready beat %0d: got %b, required 1", i, s_irdy);
        end
        checks++;
        if (ovalid !== (i == 4 || i == 8)) begin
          errors++;
          $display("FAIL full_rate_ovalid beat %0d: got %b, required %b", i, ovalid, (i == 4 || i == 8));
        end
        if (i == 4 || i == 8) begin
          want = (i == 4) ? 32'h04030201 : 32'h08070605;
          checks++;
          if (odata !== want) begin
            errors++;
            $display("FAIL full_rate_data beat %0d: got %h, required %h", i, odata, want);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'h11, 1'b0, 1'b0);
      checks++;
      if (s_irdy !== 1'b0 || s_od !== 32'h04030201 || s_ov !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall cycle %0d: iready=%b ovalid=%b odata=%h, required 0 1 04030201", c, s_irdy, s_ov, s_od);
      end
    end
    for (int b = 0; b < 4; b++) begin
      n = 0;
      do begin
        step(1'b1, DW'(8'h11 + b), 1'b0, 1'b1);
        n++;
        if (s_osh) begin
          checks++;
          e = q.pop_front();
          if (s_od !== e.w || s_ok !== e.k || s_ol !== e.l) begin
            errors++;
            $display("FAIL bp_sb: got %h/%b/%b, required %h/%b/%b", s_od, s_ok, s_ol, e.w, e.k, e.l);
          end
        end
      end while (!s_ish && n < 20);
    end
    checks++;
    if (ovalid !== 1'b1 || odata !== 32'h14131211) begin
      errors++;
      $display("FAIL bp_word: ovalid=%b odata=%h, required 1 14131211", ovalid, odata);
    end
    for (int c = 0; c < 10 && (q.size() > 0 || ovalid); c++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (s_osh) begin
        checks++;
        e = q.pop_front();
        if (s_od !== e.w || s_ok !== e.k || s_ol !== e.l) begin
          errors++;
          $display("FAIL bp_drain_sb: got %h/%b/%b, required %h/%b/%b", s_od, s_ok, s_ol, e.w, e.k, e.l);
        end
      end
    end
    checks++;
    if (q.size() != 0 || ovalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: pending=%0d ovalid=%b, required 0 0", q.size(), ovalid);
    end
  endtask

`ifdef STR_PACK_LAST_EN
  task automatic test_partial_flush();
    exp_t e;
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b1, 1'b1);
    checks++;
    if (ovalid !== 1'b1 || odata !== 32'h0000A2A1 || okeep !== 4'b0011 || olast !== 1'b1) begin
      errors++;
      $display("FAIL partial: ovalid=%b odata=%h okeep=%b olast=%b, required 1 0000a2a1 0011 1", ovalid, odata, okeep, olast);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(1'b1, DW'(8'hB1 + i), 1'b0, 1'b1);
      else       step(1'b0, '0, 1'b0, 1'b1);
      if (s_osh) begin
        checks++;
        e = q.pop_front();
        if (s_od !== e.w || s_ok !== e.k || s_ol !== e.l) begin
          errors++;
          $display("FAIL partial_sb: got %h/%b/%b, required %h/%b/%b", s_od, s_ok, s_ol, e.w, e.k, e.l);
        end
      end
      if (i == 3) begin
        checks++;
        if (odata !== 32'hB4B3B2B1 || okeep !== 4'b1111 || olast !== 1'b0) begin
          errors++;
          $display("FAIL partial_next: odata=%h okeep=%b olast=%b, required b4b3b2b1 1111 0", odata, okeep, olast);
        end
      end
    end
  endtask

  task automatic test_lane0_last();
    exp_t e;
    step(1'b1, 8'hC5, 1'b1, 1'b1);
    checks++;
    if (ovalid !== 1'b1 || odata !== 32'h000000C5 || okeep !== 4'b0001 || olast !== 1'b1) begin
      errors++;
      $display("FAIL lane0_last: ovalid=%b odata=%h okeep=%b olast=%b, required 1 000000c5 0001 1", ovalid, odata, okeep, olast);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (!s_osh || q.size() == 0) begin
      errors++;
      $display("FAIL lane0_sb: osh=%b pending=%0d, required 1 >0", s_osh, q.size());
    end else begin
      e = q.pop_front();
      if (s_od !== e.w || s_ok !== e.k || s_ol !== e.l) begin
        errors++;
        $display("FAIL lane0_sb: got %h/%b/%b, required %h/%b/%b", s_od, s_ok, s_ol, e.w, e.k, e.l);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_word();
    exp_t e;
    step(1'b1, 8'h21, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    checks++;
    if (ovalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: ovalid=%b, required 0", ovalid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, DW'(8'h31 + i), 1'b0, 1'b1);
      checks++;
      if (ovalid !== (i == 3)) begin
        errors++;
        $display("FAIL rst_mid_ovalid beat %0d: got %b, required %b", i, ovalid, (i == 3));
      end
    end
    checks++;
    if (odata !== 32'h34333231) begin
      errors++;
      $display("FAIL rst_mid_data: got %h, required 34333231", odata);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (!s_osh || q.size() == 0) begin
      errors++;
      $display("FAIL rst_mid_sb: osh=%b pending=%0d, required 1 >0", s_osh, q.size());
    end else begin
      e = q.pop_front();
      if (s_od !== e.w || s_ok !== e.k || s_ol !== e.l) begin
        errors++;
        $display("FAIL rst_mid_sb: got %h/%b/%b, required %h/%b/%b", s_od, s_ok, s_ol, e.w, e.k, e.l);
      end
    end
  endtask

  task automatic test_random();
    exp_t          e;
    logic          have, v, l, r, prev_hold;
    logic [DW-1:0] d;
    logic [OW-1:0] prev_od;
    int            sent, cyc;
    have = 1'b0; prev_hold = 1'b0; prev_od = '0; d = '0; l = 1'b0;
    sent = 0; cyc = 0;
    while (cyc < 20000 && (sent < 1000 || q.size() > 0 || ovalid)) begin
      if (!have && sent < 1000) begin
        d    = DW'($urandom);
        l    = LAST_EN & ($urandom_range(0, 7) == 0);
        have = 1'b1;
      end
      v = have & ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      step(v, d, l, r);
      cyc++;
      checks++;
      if (s_irdy !== (~s_ov | r)) begin
        errors++;
        $display("FAIL rand_iready cycle %0d: got %b, required %b", cyc, s_irdy, ~s_ov | r);
      end
      if (prev_hold) begin
        checks++;
        if (s_od !== prev_od || s_ov !== 1'b1) begin
          errors++;
          $display("FAIL rand_hold cycle %0d: odata=%h ovalid=%b, required %h 1", cyc, s_od, s_ov, prev_od);
        end
      end
      prev_hold = s_ov & ~r;
      prev_od   = s_od;
      if (s_ish) begin
        have = 1'b0;
        sent++;
      end
      if (s_osh) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_sb cycle %0d: unexpected word %h", cyc, s_od);
        end else begin
          e = q.pop_front();
          if (s_od !== e.w || s_ok !== e.k || s_ol !== e.l) begin
            errors++;
            $display("FAIL rand_sb cycle %0d: got %h/%b/%b, required %h/%b/%b", cyc, s_od, s_ok, s_ol, e.w, e.k, e.l);
          end
        end
      end
    end
    checks++;
    if (sent != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_done: sent=%0d pending=%0d, required 1000 0", sent, q.size());
    end
  endtask

  initial begin
    rst = 1'b1; ivalid = 1'b0; idata = '0; oready = 1'b0;
`ifdef STR_PACK_LAST_EN
    ilast = 1'b0;
`endif
    m_word = '0; m_keep = '0; m_wc = 0;
    @(negedge clk);
    test_reset();
    test_full_rate();
    test_backpressure();
`ifdef STR_PACK_LAST_EN
    test_partial_flush();
    test_lane0_last();
`endif
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
